// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH storage with one synchronous write port and two
// independent registered read ports, per-port read valid flags, single-cycle
// whole-array clear and an out-of-range write error flag.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to a
// read of the same address. Without it, such a read sees the pre-write contents.
module register_file #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid_b,
  output logic              wr_err
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_in_range;
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;

  // DEPTH need not be a power of two, so the top of the address space is invalid
  assign wr_in_range = (32'(wr_addr) < DEPTH);

  // Read mux per port; unmatched (out-of-range) addresses and clear cycles give 0
  always_comb begin
    rd_next_a = '0;
    rd_next_b = '0;
    if (!clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_addr_a == ADDR_W'(i)) rd_next_a = mem_q[i];
        if (rd_addr_b == ADDR_W'(i)) rd_next_b = mem_q[i];
      end
`ifdef RF_BYPASS_EN
      if (wr_en && wr_in_range && (wr_addr == rd_addr_a)) rd_next_a = wr_data;
      if (wr_en && wr_in_range && (wr_addr == rd_addr_b)) rd_next_b = wr_data;
`endif
    end
  end

  // Storage array: reset and clear zero everything, clear drops a concurrent write
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rst || clr) begin
        mem_q[i] <= '0;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // Registered read ports: data holds while idle, valid follows the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) rd_data_a <= rd_next_a;
      if (rd_en_b) rd_data_b <= rd_next_b;
    end
  end

  // Write error flag: updated on every write attempt, held otherwise
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_err <= 1'b0;
    end else if (wr_en) begin
      wr_err <= !wr_in_range;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file (WIDTH=8, DEPTH=6, ADDR_W=3).
// Follows RF_BYPASS_EN the same way as the design build.
module tb_register_file;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 6;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              rd_en_a = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [WIDTH-1:0]  rd_data_a;
  logic              rd_valid_a;
  logic              rd_en_b = 1'b0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_valid_b;
  logic              wr_err;

  register_file #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_valid_a(rd_valid_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .rd_valid_b(rd_valid_b),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       va;
    bit [7:0] da;
    bit       vb;
    bit [7:0] db;
    bit       err;
  } status_t;

  // Reference model state
  bit [7:0] model_mem [DEPTH];
  bit [7:0] held_a, held_b;
  bit       model_err;
  bit       bypass_on;

  bit [7:0] qa [$];
  bit [7:0] qb [$];
  status_t  stq [$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a read request sees, computed from the pre-edge model contents
  function automatic bit [7:0] model_read(input bit c, input bit we, input int wa,
                                          input bit [7:0] wd, input int ra);
    if (c) return 8'h00;
    if (ra >= int'(DEPTH)) return 8'h00;
    if (bypass_on && we && wa == ra) return wd;
    return model_mem[ra];
  endfunction

  // Drive one cycle of stimulus and push the expected response
  task automatic step(input bit r, input bit c, input bit we, input int wa, input bit [7:0] wd,
                      input bit ea, input int aa, input bit eb, input int ab);
    status_t s;
    @(negedge clk);
    rst = r; clr = c; wr_en = we; wr_addr = ADDR_W'(wa); wr_data = wd;
    rd_en_a = ea; rd_addr_a = ADDR_W'(aa); rd_en_b = eb; rd_addr_b = ADDR_W'(ab);
    if (r) begin
      foreach (model_mem[i]) model_mem[i] = 8'h00;
      held_a = 8'h00; held_b = 8'h00; model_err = 1'b0;
      s.va = 1'b0; s.vb = 1'b0;
    end else begin
      if (ea) begin
        held_a = model_read(c, we, wa, wd, aa);
        qa.push_back(held_a);
      end
      if (eb) begin
        held_b = model_read(c, we, wa, wd, ab);
        qb.push_back(held_b);
      end
      s.va = ea; s.vb = eb;
      if (c) begin
        foreach (model_mem[i]) model_mem[i] = 8'h00;
        model_err = 1'b0;
      end else if (we) begin
        if (wa < int'(DEPTH)) begin
          model_mem[wa] = wd;
          model_err = 1'b0;
        end else begin
          model_err = 1'b1;
        end
      end
    end
    s.da = held_a; s.db = held_b; s.err = model_err;
    stq.push_back(s);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents after each edge
  initial begin
    status_t s;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid_a === 1'b1) begin
        if (qa.size() == 0) begin
          check("unexpected_valid_a", 32'(rd_valid_a), 32'd0);
        end else begin
          check("rd_data_a", 32'(rd_data_a), 32'(qa.pop_front()));
        end
      end
      if (rd_valid_b === 1'b1) begin
        if (qb.size() == 0) begin
          check("unexpected_valid_b", 32'(rd_valid_b), 32'd0);
        end else begin
          check("rd_data_b", 32'(rd_data_b), 32'(qb.pop_front()));
        end
      end
      if (stq.size() > 0) begin
        s = stq.pop_front();
        check("rd_valid_a", 32'(rd_valid_a), 32'(s.va));
        check("rd_valid_b", 32'(rd_valid_b), 32'(s.vb));
        check("held_data_a", 32'(rd_data_a), 32'(s.da));
        check("held_data_b", 32'(rd_data_b), 32'(s.db));
        check("wr_err", 32'(wr_err), 32'(s.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef RF_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    // Reset for two cycles, with a read issued in the reset cycle that must be discarded
    step(1, 0, 0, 0, 8'h00, 1, 1, 1, 2);
    step(1, 0, 1, 2, 8'h55, 1, 2, 1, 3);
    idle();
    // Read every address on both ports, including the out-of-range ones
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 8'h00, 1, i, 1, 7 - i);
    // Write then read on both ports
    step(0, 0, 1, 3, 8'hA5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00, 1, 3, 1, 3);
    // Same-cycle write and read of one address
    step(0, 0, 1, 5, 8'h3C, 0, 0, 0, 0);
    step(0, 0, 1, 5, 8'hFF, 1, 5, 1, 4);
    step(0, 0, 0, 0, 8'h00, 1, 5, 0, 0);
    // Out-of-range write, held error flag, then clear by a valid write
    step(0, 0, 1, 6, 8'h77, 0, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00, 1, 6, 1, 5);
    step(0, 0, 1, 7, 8'h12, 1, 0, 1, 1);
    step(0, 0, 1, 1, 8'h21, 1, 2, 1, 3);
    // Fill, then clear with a concurrent write and read
    for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 1, i, 8'(8'h80 + i), 0, 0, 0, 0);
    step(0, 0, 1, 6, 8'h01, 0, 0, 0, 0);
    step(0, 1, 1, 0, 8'h11, 1, 2, 1, 0);
    for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 0, 0, 8'h00, 1, i, 1, i);
    // Alternating reads with a gap every third cycle
    for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 1, i, 8'(8'h40 + 3 * i), 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      bit en;
      en = (i % 3) != 2;
      step(0, 0, 0, 0, 8'h00, en, i % 6, en, (i + 3) % 6);
    end
    // Reset mid-stream with reads in flight
    step(0, 0, 0, 0, 8'h00, 1, 1, 1, 2);
    step(1, 0, 1, 4, 8'h99, 1, 4, 1, 4);
    step(0, 0, 0, 0, 8'h00, 0, 0, 1, 4);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0), 1'($urandom),
           int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
           1'($urandom), int'($urandom_range(0, 7)));
    end
    idle();
    idle();
    @(posedge clk);
    #2;
    check("pending_reads_a", 32'(qa.size()), 32'd0);
    check("pending_reads_b", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
